// File: rtl/idecode_pipe.sv
// idecode_pipe: decode stage with register bank, WB bypass, hazard detection, branch resolution and ID/EX register
// Ports: i_clock/i_reset (async active-low) clock and reset; i_enable freezes all state when low;
//        i_valid/i_inst/i_pc the IF/ID instruction; i_wb_* write-back port; i_ex_* hazard info from ID/EX;
//        i_dbg_addr/o_dbg_data debug read; o_stall/o_flush/o_target combinational pipeline control;
//        o_valid..o_pc the registered ID/EX contents.
`timescale 1ns/1ps
module idecode_pipe #(
    parameter int DATA_SIZE = 32,
    parameter int REG_SIZE  = 5,
    parameter int INST_SIZE = 32,
    parameter int PC_SIZE   = 32
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_valid,
    input  logic [INST_SIZE-1:0] i_inst,
    input  logic [PC_SIZE-1:0]   i_pc,
    input  logic                 i_wb_reg_write,
    input  logic [REG_SIZE-1:0]  i_wb_addr,
    input  logic [DATA_SIZE-1:0] i_wb_data,
    input  logic                 i_ex_mem_read,
    input  logic                 i_ex_reg_write,
    input  logic [REG_SIZE-1:0]  i_ex_dest,
    input  logic [REG_SIZE-1:0]  i_dbg_addr,
    output logic [DATA_SIZE-1:0] o_dbg_data,
    output logic                 o_stall,
    output logic                 o_flush,
    output logic [PC_SIZE-1:0]   o_target,
    output logic                 o_valid,
    output logic                 o_reg_write,
    output logic                 o_mem_read,
    output logic                 o_mem_write,
    output logic                 o_halt,
    output logic [1:0]           o_reg_dest,
    output logic [DATA_SIZE-1:0] o_data_a,
    output logic [DATA_SIZE-1:0] o_data_b,
    output logic [DATA_SIZE-1:0] o_imm,
    output logic [REG_SIZE-1:0]  o_rs,
    output logic [REG_SIZE-1:0]  o_rt,
    output logic [REG_SIZE-1:0]  o_rd,
    output logic [PC_SIZE-1:0]   o_pc
);
    localparam int DEPTH = 2 ** REG_SIZE;

    logic [DATA_SIZE-1:0] bank [DEPTH];
    logic [5:0]           op, fn;
    logic [REG_SIZE-1:0]  rs, rt, rd;
    logic [DATA_SIZE-1:0] data_a, data_b, imm;
    logic                 is_r, is_jr, is_jalr, is_load, is_store, is_ialu;
    logic                 is_jal, is_beq, is_bne, is_j, is_hlt, is_branch;
    logic                 dec_write;
    logic [1:0]           dec_dest;
    logic                 load_use, ctrl_dep, taken, bubble;
    logic [PC_SIZE-1:0]   br_target, j_target;

    assign op = i_inst[31:26];
    assign fn = i_inst[5:0];
    assign rs = REG_SIZE'(i_inst[25:21]);
    assign rt = REG_SIZE'(i_inst[20:16]);
    assign rd = REG_SIZE'(i_inst[15:11]);
    assign imm = {{(DATA_SIZE-16){i_inst[15]}}, i_inst[15:0]};

    // Reads see the write-back value of the same cycle; r0 is never written so it reads 0.
    assign data_a     = (i_wb_reg_write && i_wb_addr == rs && rs != '0) ? i_wb_data : bank[rs];
    assign data_b     = (i_wb_reg_write && i_wb_addr == rt && rt != '0) ? i_wb_data : bank[rt];
    assign o_dbg_data = (i_wb_reg_write && i_wb_addr == i_dbg_addr && i_dbg_addr != '0) ? i_wb_data : bank[i_dbg_addr];

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
        end else if (i_enable && i_wb_reg_write && i_wb_addr != '0) begin
            bank[i_wb_addr] <= i_wb_data;
        end
    end

    assign is_r      = op == 6'h00;
    assign is_jr     = is_r && fn == 6'h08;
    assign is_jalr   = is_r && fn == 6'h09;
    assign is_load   = op >= 6'h20 && op <= 6'h25;
    assign is_store  = op >= 6'h28 && op <= 6'h2B;
    assign is_ialu   = op >= 6'h08 && op <= 6'h0F;
    assign is_jal    = op == 6'h03;
    assign is_beq    = op == 6'h04;
    assign is_bne    = op == 6'h05;
    assign is_j      = op == 6'h02;
    assign is_hlt    = op == 6'h3F;
    assign is_branch = is_beq || is_bne;
    assign dec_write = (is_r && !is_jr) || is_load || is_ialu || is_jal;
    assign dec_dest  = (is_jal || is_jalr) ? 2'd2 : is_r ? 2'd1 : 2'd0;

    // rt is a true source only for R-type, branches and stores; loads and I-ALU write it.
    assign load_use = i_ex_mem_read && i_ex_dest != '0 &&
                      (i_ex_dest == rs || (i_ex_dest == rt && (is_r || is_branch || is_store)));
    // Branches and register jumps resolve here, so any pending ALU result they read must land first.
    assign ctrl_dep = (is_branch || is_jr || is_jalr) && i_ex_reg_write && i_ex_dest != '0 &&
                      (i_ex_dest == rs || (is_branch && i_ex_dest == rt));
    assign o_stall  = i_valid && !o_halt && (load_use || ctrl_dep);

    assign taken   = (is_beq && data_a == data_b) || (is_bne && data_a != data_b) ||
                     is_j || is_jal || is_jr || is_jalr;
    assign o_flush = i_valid && !o_stall && !o_halt && taken;

    assign br_target = i_pc + {{(PC_SIZE-16){i_inst[15]}}, i_inst[15:0]};
    assign j_target  = {i_pc[PC_SIZE-1:26], i_inst[25:0]};
    assign o_target  = !o_flush ? '0 : is_branch ? br_target : (is_j || is_jal) ? j_target : data_a[PC_SIZE-1:0];

    assign bubble = o_stall || !i_valid || o_halt;

    // o_halt doubles as the sticky halted flag: bubbles leave it untouched.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_valid     <= 1'b0;
            o_reg_write <= 1'b0;
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
            o_halt      <= 1'b0;
            o_reg_dest  <= 2'd0;
            o_data_a    <= '0;
            o_data_b    <= '0;
            o_imm       <= '0;
            o_rs        <= '0;
            o_rt        <= '0;
            o_rd        <= '0;
            o_pc        <= '0;
        end else if (i_enable) begin
            if (bubble) begin
                o_valid     <= 1'b0;
                o_reg_write <= 1'b0;
                o_mem_read  <= 1'b0;
                o_mem_write <= 1'b0;
                o_reg_dest  <= 2'd0;
                o_data_a    <= '0;
                o_data_b    <= '0;
                o_imm       <= '0;
                o_rs        <= '0;
                o_rt        <= '0;
                o_rd        <= '0;
                o_pc        <= '0;
            end else begin
                o_valid     <= 1'b1;
                o_reg_write <= dec_write;
                o_mem_read  <= is_load;
                o_mem_write <= is_store;
                o_halt      <= is_hlt;
                o_reg_dest  <= dec_dest;
                o_data_a    <= data_a;
                o_data_b    <= data_b;
                o_imm       <= imm;
                o_rs        <= rs;
                o_rt        <= rt;
                o_rd        <= rd;
                o_pc        <= i_pc;
            end
        end
    end
endmodule

// File: tb/tb_idecode_pipe.sv
// tb_idecode_pipe: directed and randomized checks of idecode_pipe against a behavioural model
`timescale 1ns/1ps
module tb_idecode_pipe;
    logic        clk = 1'b0;
    logic        i_reset, i_enable, i_valid, i_wb_reg_write, i_ex_mem_read, i_ex_reg_write;
    logic [31:0] i_inst, i_pc, i_wb_data;
    logic [4:0]  i_wb_addr, i_ex_dest, i_dbg_addr;
    logic [31:0] o_dbg_data, o_target, o_data_a, o_data_b, o_imm, o_pc;
    logic        o_stall, o_flush, o_valid, o_reg_write, o_mem_read, o_mem_write, o_halt;
    logic [1:0]  o_reg_dest;
    logic [4:0]  o_rs, o_rt, o_rd;

    typedef struct packed {
        logic v, rw, mr, mw, h;
        logic [1:0] dst;
        logic [31:0] a, b, imm;
        logic [4:0] rs, rt, rdf;
        logic [31:0] pc;
    } idex_t;

    idex_t       act, e, nxt;
    logic [31:0] mregs [32];
    logic        p_stall, p_flush;
    logic [31:0] p_target;
    int          checks = 0, passed = 0;

    always #5 clk = ~clk;

    idecode_pipe dut (
        .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
        .i_inst(i_inst), .i_pc(i_pc), .i_wb_reg_write(i_wb_reg_write), .i_wb_addr(i_wb_addr),
        .i_wb_data(i_wb_data), .i_ex_mem_read(i_ex_mem_read), .i_ex_reg_write(i_ex_reg_write),
        .i_ex_dest(i_ex_dest), .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data),
        .o_stall(o_stall), .o_flush(o_flush), .o_target(o_target), .o_valid(o_valid),
        .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_halt(o_halt), .o_reg_dest(o_reg_dest), .o_data_a(o_data_a), .o_data_b(o_data_b),
        .o_imm(o_imm), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_pc(o_pc)
    );

    assign act = {o_valid, o_reg_write, o_mem_read, o_mem_write, o_halt, o_reg_dest,
                  o_data_a, o_data_b, o_imm, o_rs, o_rt, o_rd, o_pc};

    function automatic logic [31:0] rd_bank(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (i_wb_reg_write && i_wb_addr == a) return i_wb_data;
        return mregs[a];
    endfunction

    function automatic void predict();
        logic [5:0]  op = i_inst[31:26];
        logic [5:0]  fn = i_inst[5:0];
        logic [4:0]  s = i_inst[25:21];
        logic [4:0]  t = i_inst[20:16];
        logic [31:0] a = rd_bank(s);
        logic [31:0] b = rd_bank(t);
        logic [31:0] sx = {{16{i_inst[15]}}, i_inst[15:0]};
        bit r = 0, jr = 0, jalr = 0, ld = 0, st = 0, br = 0, jmp = 0, hl = 0, wr = 0, tk = 0, rt_src = 0;
        logic [1:0] dst = 0;
        case (op) inside
            6'h00: begin r = 1; jr = fn == 6'h08; jalr = fn == 6'h09; wr = !jr; dst = jalr ? 2 : 1; rt_src = 1; end
            [6'h20:6'h25]: begin ld = 1; wr = 1; end
            [6'h28:6'h2B]: begin st = 1; rt_src = 1; end
            [6'h08:6'h0F]: wr = 1;
            6'h03: begin jmp = 1; wr = 1; dst = 2; end
            6'h04: begin br = 1; rt_src = 1; tk = a == b; end
            6'h05: begin br = 1; rt_src = 1; tk = a != b; end
            6'h02: jmp = 1;
            6'h3F: hl = 1;
            default: ;
        endcase
        if (jr || jalr) tk = 1;
        if (jmp) tk = 1;
        p_stall = i_valid && !e.h && i_ex_dest != 0 &&
                  ((i_ex_mem_read && (i_ex_dest == s || (rt_src && i_ex_dest == t))) ||
                   ((br || jr || jalr) && i_ex_reg_write && (i_ex_dest == s || (br && i_ex_dest == t))));
        p_flush = i_valid && !p_stall && !e.h && tk;
        p_target = 0;
        if (p_flush) p_target = br ? i_pc + sx : jmp ? {i_pc[31:26], i_inst[25:0]} : a;
        if (!i_enable) nxt = e;
        else if (p_stall || !i_valid || e.h) begin nxt = '0; nxt.h = e.h; end
        else nxt = '{v: 1, rw: wr, mr: ld, mw: st, h: hl, dst: dst, a: a, b: b, imm: sx,
                     rs: s, rt: t, rdf: i_inst[15:11], pc: i_pc};
    endfunction

    task automatic tick();
        predict();
        @(posedge clk); #1;
        if (i_enable && i_wb_reg_write && i_wb_addr != 0) mregs[i_wb_addr] = i_wb_data;
        e = nxt;
    endtask

    task automatic set_idle();
        i_enable = 1; i_valid = 0; i_inst = 0; i_pc = 0; i_wb_reg_write = 0; i_wb_addr = 0;
        i_wb_data = 0; i_ex_mem_read = 0; i_ex_reg_write = 0; i_ex_dest = 0; i_dbg_addr = 0;
    endtask

    task automatic apply_reset();
        i_reset = 0; #2;
        for (int k = 0; k < 32; k++) mregs[k] = 0;
        e = '0;
    endtask

    task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
        set_idle();
        i_wb_reg_write = 1; i_wb_addr = addr; i_wb_data = data;
        tick();
        i_wb_reg_write = 0;
    endtask

    task automatic test_reset();
        i_reset = 1; set_idle();
        i_valid = 1; i_inst = 32'h0043_2020;
        tick();
        apply_reset();
        checks++; if (act !== '0) $display("FAIL reset_idex got %h want 0", act); else passed++;
        for (int k = 1; k < 4; k++) begin
            i_dbg_addr = 5'(k); #1;
            checks++; if (o_dbg_data !== 32'h0) $display("FAIL reset_bank r%0d got %h want 0", k, o_dbg_data); else passed++;
        end
        i_reset = 1;
        set_idle();
        tick();
    endtask

    task automatic test_r0();
        set_idle();
        i_wb_reg_write = 1; i_wb_addr = 0; i_wb_data = 32'hFFFF; i_dbg_addr = 0; #1;
        checks++; if (o_dbg_data !== 32'h0) $display("FAIL r0_bypass got %h want 0", o_dbg_data); else passed++;
        tick();
        i_wb_reg_write = 0; #1;
        checks++; if (o_dbg_data !== 32'h0) $display("FAIL r0_write got %h want 0", o_dbg_data); else passed++;
        i_wb_reg_write = 1; i_wb_addr = 9; i_dbg_addr = 9; #1;
        checks++; if (o_dbg_data !== 32'hFFFF) $display("FAIL r9_bypass got %h want ffff", o_dbg_data); else passed++;
        tick();
    endtask

    task automatic test_bypass();
        set_idle();
        i_valid = 1; i_inst = {6'h00, 5'd5, 5'd0, 5'd6, 5'd0, 6'h20}; i_pc = 32'h40;
        i_wb_reg_write = 1; i_wb_addr = 5; i_wb_data = 32'h1234;
        tick();
        checks++; if (o_data_a !== 32'h1234) $display("FAIL bypass_a got %h want 1234", o_data_a); else passed++;
        checks++; if ({o_valid, o_reg_write, o_reg_dest, o_rd, o_pc} !== {1'b1, 1'b1, 2'd1, 5'd6, 32'h40})
            $display("FAIL bypass_ctl got %b%b %0d %0d %h want 1 1 1 6 40", o_valid, o_reg_write, o_reg_dest, o_rd, o_pc);
        else passed++;
        i_wb_reg_write = 0;
        tick();
        checks++; if (o_data_a !== 32'h1234) $display("FAIL bank_r5 got %h want 1234", o_data_a); else passed++;
    endtask

    task automatic test_load_use();
        set_idle();
        i_valid = 1; i_inst = {6'h00, 5'd3, 5'd2, 5'd4, 5'd0, 6'h20};
        i_ex_mem_read = 1; i_ex_dest = 3; #1;
        checks++; if ({o_stall, o_flush} !== 2'b10) $display("FAIL lu_stall got %b%b want 10", o_stall, o_flush); else passed++;
        tick();
        checks++; if ({o_valid, o_reg_write} !== 2'b00) $display("FAIL lu_bubble got %b%b want 00", o_valid, o_reg_write); else passed++;
        i_ex_dest = 2; #1;
        checks++; if (o_stall !== 1'b1) $display("FAIL lu_rt_rtype got %b want 1", o_stall); else passed++;
        i_ex_dest = 0; #1;
        checks++; if (o_stall !== 1'b0) $display("FAIL lu_r0 got %b want 0", o_stall); else passed++;
        i_ex_mem_read = 0; i_ex_dest = 3; #1;
        checks++; if (o_stall !== 1'b0) $display("FAIL lu_clear got %b want 0", o_stall); else passed++;
        tick();
        checks++; if ({o_valid, o_rs, o_rt, o_rd} !== {1'b1, 5'd3, 5'd2, 5'd4})
            $display("FAIL lu_resume got %b %0d %0d %0d want 1 3 2 4", o_valid, o_rs, o_rt, o_rd);
        else passed++;
        i_inst = {6'h23, 5'd1, 5'd2, 16'h0}; i_ex_mem_read = 1; i_ex_dest = 2; #1;
        checks++; if (o_stall !== 1'b0) $display("FAIL lu_load_rt got %b want 0", o_stall); else passed++;
        tick();
        checks++; if ({o_mem_read, o_reg_write, o_reg_dest} !== {1'b1, 1'b1, 2'd0})
            $display("FAIL load_ctl got %b%b %0d want 1 1 0", o_mem_read, o_reg_write, o_reg_dest);
        else passed++;
    endtask

    task automatic test_branch();
        wb_write(1, 7);
        wb_write(2, 7);
        i_valid = 1; i_inst = {6'h04, 5'd1, 5'd2, 16'hFFFE}; i_pc = 32'h10; #1;
        checks++; if ({o_flush, o_target} !== {1'b1, 32'h0E}) $display("FAIL beq_taken got %b %h want 1 0e", o_flush, o_target); else passed++;
        tick();
        wb_write(2, 8);
        i_valid = 1; i_inst = {6'h04, 5'd1, 5'd2, 16'hFFFE}; i_pc = 32'h10; #1;
        checks++; if ({o_flush, o_target} !== {1'b0, 32'h0}) $display("FAIL beq_not_taken got %b %h want 0 0", o_flush, o_target); else passed++;
        i_inst = {6'h05, 5'd1, 5'd2, 16'hFFFE}; #1;
        checks++; if ({o_flush, o_target} !== {1'b1, 32'h0E}) $display("FAIL bne_taken got %b %h want 1 0e", o_flush, o_target); else passed++;
        i_pc = 32'h0; #1;
        checks++; if (o_target !== 32'hFFFF_FFFE) $display("FAIL br_wrap got %h want fffffffe", o_target); else passed++;
        i_ex_mem_read = 1; i_ex_reg_write = 1; i_ex_dest = 2; #1;
        checks++; if ({o_stall, o_flush} !== 2'b10) $display("FAIL dual_stall got %b%b want 10", o_stall, o_flush); else passed++;
        tick();
        checks++; if (o_valid !== 1'b0) $display("FAIL dual_bubble got %b want 0", o_valid); else passed++;
        i_ex_mem_read = 0; i_ex_reg_write = 0; i_ex_dest = 0;
        i_inst = {6'h02, 26'h123}; i_pc = 32'hA000_0010; #1;
        checks++; if ({o_flush, o_target} !== {1'b1, 32'hA000_0123}) $display("FAIL j_target got %b %h want 1 a0000123", o_flush, o_target); else passed++;
        tick();
    endtask

    task automatic test_jr();
        wb_write(31, 32'h55);
        i_valid = 1; i_inst = {6'h00, 5'd31, 15'd0, 6'h08}; i_pc = 32'h20;
        i_ex_reg_write = 1; i_ex_dest = 31; #1;
        checks++; if ({o_stall, o_flush, o_target} !== {2'b10, 32'h0}) $display("FAIL jr_stall got %b%b %h want 10 0", o_stall, o_flush, o_target); else passed++;
        tick();
        i_ex_reg_write = 0; #1;
        checks++; if ({o_flush, o_target} !== {1'b1, 32'h55}) $display("FAIL jr_redirect got %b %h want 1 55", o_flush, o_target); else passed++;
        tick();
        checks++; if ({o_valid, o_reg_write} !== 2'b10) $display("FAIL jr_idex got %b%b want 10", o_valid, o_reg_write); else passed++;
        i_inst = {6'h00, 5'd31, 15'd0, 6'h09}; #1;
        checks++; if ({o_flush, o_target} !== {1'b1, 32'h55}) $display("FAIL jalr_redirect got %b %h want 1 55", o_flush, o_target); else passed++;
        tick();
        checks++; if ({o_reg_write, o_reg_dest} !== {1'b1, 2'd2}) $display("FAIL jalr_dest got %b %0d want 1 2", o_reg_write, o_reg_dest); else passed++;
    endtask

    task automatic test_enable();
        set_idle();
        i_valid = 1; i_inst = {6'h00, 5'd1, 5'd2, 5'd7, 5'd0, 6'h20}; i_pc = 32'h77;
        tick();
        i_enable = 0; i_inst = {6'h2B, 5'd1, 5'd2, 16'h4}; i_pc = 32'h99;
        i_wb_reg_write = 1; i_wb_addr = 12; i_wb_data = 32'hABC;
        tick();
        checks++; if ({o_valid, o_mem_write, o_rd, o_pc} !== {1'b1, 1'b0, 5'd7, 32'h77})
            $display("FAIL enable_hold got %b%b %0d %h want 1 0 7 77", o_valid, o_mem_write, o_rd, o_pc);
        else passed++;
        set_idle(); i_dbg_addr = 12; #1;
        checks++; if (o_dbg_data !== 32'h0) $display("FAIL enable_nowrite got %h want 0", o_dbg_data); else passed++;
        tick();
    endtask

    task automatic test_halt();
        set_idle();
        i_valid = 1; i_inst = {6'h3F, 26'h0}; i_pc = 32'h30;
        tick();
        checks++; if ({o_halt, o_valid} !== 2'b11) $display("FAIL halt_load got %b%b want 11", o_halt, o_valid); else passed++;
        i_inst = {6'h00, 5'd3, 5'd2, 5'd4, 5'd0, 6'h20}; i_ex_mem_read = 1; i_ex_dest = 3; #1;
        checks++; if (o_stall !== 1'b0) $display("FAIL halt_nostall got %b want 0", o_stall); else passed++;
        tick();
        checks++; if ({o_halt, o_valid, o_reg_write} !== 3'b100) $display("FAIL halt_bubble got %b%b%b want 100", o_halt, o_valid, o_reg_write); else passed++;
        i_ex_mem_read = 0; i_inst = {6'h02, 26'h40}; #1;
        checks++; if (o_flush !== 1'b0) $display("FAIL halt_noflush got %b want 0", o_flush); else passed++;
        tick();
        checks++; if (o_halt !== 1'b1) $display("FAIL halt_sticky got %b want 1", o_halt); else passed++;
        apply_reset();
        checks++; if (o_halt !== 1'b0) $display("FAIL halt_reset got %b want 0", o_halt); else passed++;
        i_reset = 1;
        i_inst = {6'h00, 5'd3, 5'd2, 5'd4, 5'd0, 6'h20};
        tick();
        checks++; if ({o_halt, o_valid} !== 2'b01) $display("FAIL halt_resume got %b%b want 01", o_halt, o_valid); else passed++;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0] ops [13] = '{6'h00, 6'h00, 6'h20, 6'h25, 6'h2B, 6'h28, 6'h08, 6'h0F, 6'h03, 6'h04, 6'h05, 6'h02, 6'h11};
        logic [5:0] fns [4] = '{6'h20, 6'h08, 6'h09, 6'h2A};
        return {ops[$urandom_range(0, 12)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom), fns[$urandom_range(0, 3)]};
    endfunction

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            i_enable = $urandom_range(0, 9) != 0;
            i_valid = $urandom_range(0, 6) != 0;
            i_inst = rand_inst();
            i_pc = $urandom;
            i_wb_reg_write = 1'($urandom_range(0, 1));
            i_wb_addr = 5'($urandom_range(0, 7));
            i_wb_data = $urandom_range(0, 3) == 0 ? 32'h7 : $urandom;
            i_ex_mem_read = $urandom_range(0, 3) == 0;
            i_ex_reg_write = 1'($urandom_range(0, 1));
            i_ex_dest = 5'($urandom_range(0, 7));
            i_dbg_addr = 5'($urandom_range(0, 7));
            #1;
            predict();
            checks++; if (o_stall !== p_stall) $display("FAIL rand_stall n=%0d got %b want %b", n, o_stall, p_stall); else passed++;
            checks++; if (o_flush !== p_flush) $display("FAIL rand_flush n=%0d got %b want %b", n, o_flush, p_flush); else passed++;
            checks++; if (o_target !== p_target) $display("FAIL rand_target n=%0d got %h want %h", n, o_target, p_target); else passed++;
            checks++; if (o_dbg_data !== rd_bank(i_dbg_addr)) $display("FAIL rand_dbg n=%0d got %h want %h", n, o_dbg_data, rd_bank(i_dbg_addr)); else passed++;
            tick();
            checks++; if (act !== e) $display("FAIL rand_idex n=%0d got %h want %h", n, act, e); else passed++;
        end
    endtask

    initial begin
        i_reset = 1;
        set_idle();
        test_reset();
        test_r0();
        test_bypass();
        test_load_use();
        test_branch();
        test_jr();
        test_enable();
        test_halt();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
